data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache that sits between the pipeline's D-cache port and the 128-bit main-memory bus. It serves word reads and writes from the MEM stage. Hits complete with zero stall cycles. On a miss it holds `proc_stall` high while it writes back a dirty victim and then refills the line. Line storage, tags, valid bits and dirty bits all live in flip-flops.

## Interface
- `NUM_BLOCKS`, default 8: number of lines; power of two, 2..64. `IDX_W` = log2(`NUM_BLOCKS`).
- `TAG_W`, default 25: equals 28 − `IDX_W`; must be overridden together with `NUM_BLOCKS`.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `proc_read` input 1: word read request.
- `proc_write` input 1: word write request; takes precedence if asserted together with `proc_read`.
- `proc_addr` input 30: word address. [1:0] selects the word in the line, [IDX_W+1:2] is the index, and the upper bits are the tag.
- `proc_wdata` input 32: write data.
- `proc_stall` output 1: high while the request cannot complete this cycle.
- `proc_rdata` output 32: read data, valid when `proc_read`=1 and `proc_stall`=0.
- `mem_read` output 1: line-fill request.
- `mem_write` output 1: line write-back request.
- `mem_addr` output 28: line address, equal to word address[29:2].
- `mem_wdata` output 128: write-back line; word 0 is in [31:0].
- `mem_rdata` input 128: fill line.
- `mem_ready` input 1: one-cycle pulse that completes the current `mem_read` or `mem_write`.

## Operation
- **States:** `IDLE`, `WRITEBACK`, `ALLOCATE`.
- **Hit condition in IDLE:** valid[idx] is set and tag[idx] equals the address tag.
  - Read hit: `proc_rdata` = the selected word, combinationally.
  - Write hit: the selected word is replaced at the clock edge and dirty[idx] is set.
  - `proc_stall` is 0.
- **Miss in IDLE:** `proc_stall` is 1 in the same cycle.
  - If valid and dirty, the next state is `WRITEBACK`; otherwise it is `ALLOCATE`.
- **WRITEBACK:**
  - `mem_write`=1, `mem_addr`={tag[idx], idx}, `mem_wdata`=line[idx].
  - On `mem_ready`, go to `ALLOCATE`.
- **ALLOCATE:**
  - `mem_read`=1, `mem_addr`=`proc_addr`[29:2].
  - On `mem_ready`: line[idx] ← `mem_rdata`, tag is written, valid=1, dirty=0, go to `IDLE`.
  - The retried access then hits in `IDLE`. A write therefore merges after the fill.
- **Request stability:** the processor holds `proc_read`, `proc_write`, `proc_addr` and `proc_wdata` stable while `proc_stall`=1. The cache never latches the request.
- **Exclusive memory requests:** `mem_read` and `mem_write` are Moore outputs of the state register and are never asserted together.
- **No request:** with `proc_read`=`proc_write`=0, `proc_stall`=0 and the state stays `IDLE`.
- **Stray memory response:** `mem_ready` while in `IDLE` is ignored.

## Timing
- **Reset values:** state=`IDLE`; all valid and dirty bits are 0; `proc_stall`=0, `proc_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0. Line and tag contents are don't-care but must be deterministic (cleared to 0).
- **Hit latency:** zero stall cycles.
- **Clean miss:**
  - Request arrives in cycle 0.
  - `mem_read` rises in cycle 1.
  - `mem_ready` arrives in cycle k.
  - `IDLE` in cycle k+1, where the request hits.
  - Stall lasts cycles 0..k, i.e. k+1 cycles.
- **Dirty miss:** adds the write-back duration, from `mem_write` rising to its `mem_ready`.
- **Reset mid-miss:** state returns to `IDLE` and `mem_read`/`mem_write` drop immediately and asynchronously. No partial fill is recorded.
- **Back-to-back hits:** one access per cycle. A write hit followed by a read of the same word in the next cycle returns the new data.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_count` [15:0] and `miss_count` [15:0], both reset to 0 and saturating at 16'hFFFF.
  - `hit_count` increments on each `IDLE`-cycle hit with `proc_stall`=0.
  - `miss_count` increments once per `IDLE`→`WRITEBACK` or `IDLE`→`ALLOCATE` transition.
- `DCACHE_STATS_EN` undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset, then read 30'h0000_0010 with `mem_ready` arriving 3 cycles after `mem_read` → `mem_addr`=28'h000_0004, stall for 4 cycles, then `proc_rdata` = word 0 of the fill line.
- Write 32'hDEAD_BEEF to 30'h0000_0011 (line now resident), then read the same address on the next cycle → 0 stall cycles, `proc_rdata`=32'hDEAD_BEEF.
- Read 30'h0000_0030, which maps to the same index with a different tag and evicts the dirty line → `mem_write` first with `mem_addr`=28'h000_0004 and `mem_wdata`[63:32]=32'hDEAD_BEEF, then `mem_read` with `mem_addr`=28'h000_000C. `mem_read` and `mem_write` are never high in the same cycle.
- Assert `rst_n`=0 in the middle of `ALLOCATE` → `mem_read` drops in the same cycle. After release, reading the old address misses again.
- `proc_read`=`proc_write`=1 to a resident word → treated as a write: dirty is set and `proc_wdata` is stored.
- With `DCACHE_STATS_EN` defined: 3 hits and 2 misses → `hit_count`=3, `miss_count`=2.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between
// the MEM-stage D-cache port and a 128-bit main-memory bus. Line data, tags,
// valid and dirty bits are all held in flip-flops.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   proc_read/proc_write       word request (write wins if both are set)
//   proc_addr[29:0]            word address {tag, index, word}
//   proc_wdata[31:0]           write data
//   proc_stall                 request cannot complete this cycle
//   proc_rdata[31:0]           read data on a read hit
//   mem_read/mem_write         line fill / line write-back request
//   mem_addr[27:0]             line address
//   mem_wdata[127:0]           write-back line (word 0 in [31:0])
//   mem_rdata[127:0]           fill line
//   mem_ready                  one-cycle completion pulse from memory
//   hit_count/miss_count       saturating statistics (only with DCACHE_STATS_EN)
//
// Optional feature macro: DCACHE_STATS_EN
//
// state     | meaning
// IDLE      | serving hits; a miss selects WRITEBACK or ALLOCATE
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being fetched from memory
module data_cache #(
    parameter int NUM_BLOCKS = 8,
    parameter int TAG_W      = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [127:0]          line_q [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] addr_tag;
    logic [1:0]       word_sel;
    logic             req;
    logic             hit;
    logic             wr_hit;
    logic             fill_en;

    assign idx      = proc_addr[IDX_W+1:2];
    assign addr_tag = proc_addr[29:IDX_W+2];
    assign word_sel = proc_addr[1:0];
    assign req      = proc_read | proc_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign wr_hit   = (state_q == IDLE) && proc_write && hit;
    assign fill_en  = (state_q == ALLOCATE) && mem_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_ready outside WRITEBACK/ALLOCATE is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (mem_ready) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs; memory strobes depend on the state register only
    always_comb begin
        mem_read   = (state_q == ALLOCATE);
        mem_write  = (state_q == WRITEBACK);
        mem_addr   = '0;
        mem_wdata  = '0;
        proc_stall = 1'b1;
        proc_rdata = '0;
        case (state_q)
            IDLE: begin
                proc_stall = req && !hit;
                if (proc_read && hit) begin
                    proc_rdata = line_q[idx][{word_sel, 5'b0} +: 32];
                end
            end
            WRITEBACK: begin
                mem_addr  = {tag_q[idx], idx};
                mem_wdata = line_q[idx];
            end
            ALLOCATE: begin
                mem_addr = proc_addr[29:2];
            end
            default: ;
        endcase
    end

    // Line storage; a write merges only on an IDLE hit, so a write miss
    // lands after the refill when the held request retries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                line_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            line_q[idx]  <= mem_rdata;
            tag_q[idx]   <= addr_tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_hit) begin
            line_q[idx][{word_sel, 5'b0} +: 32] <= proc_wdata;
            dirty_q[idx] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && req && hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if ((state_q == IDLE) && (state_d != IDLE) && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready;
    logic         resp_ready = 1'b0;
    logic         stray_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    assign mem_ready = resp_ready | stray_ready;

    data_cache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 3;

    // main memory: lines never written hold a pattern derived from the address
    logic [127:0] mem_model [logic [27:0]];

    typedef struct {
        bit           is_wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } ev_t;
    ev_t ev_log[$];

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {4'hC, a[25:2], 2'b00, a[1:0]};
    endfunction

    function automatic logic [127:0] rd_line(input logic [27:0] la);
        logic [127:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
        return l;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // memory responder: answers after lat cycles of a held request
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            if (rst_n && (mem_read || mem_write)) begin
                cnt++;
                if (cnt >= lat) begin
                    resp_ready = 1'b1;
                    cnt = 0;
                    if (mem_write) begin
                        mem_model[mem_addr] = mem_wdata;
                        ev_log.push_back('{1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = rd_line(mem_addr);
                        ev_log.push_back('{1'b0, mem_addr, mem_rdata});
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the completing cycle
    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, output int stalls,
                          output logic [31:0] rdata);
        bit done = 1'b0;
        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
        stalls = 0;
        rdata = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                checks++;
                if (mem_read && mem_write) begin
                    errors++;
                    $display("FAIL mem_excl actual=both_high required=exclusive");
                end
            end
            if (!proc_stall) begin
                rdata = proc_rdata;
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout actual=stalled required=complete addr=%h", a);
        end
        @(posedge clk);
        #1;
        proc_read = 1'b0;
        proc_write = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wd;
        int          exp_stall;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    bit          rvalid [8];
    bit          rdirty [8];
    logic [24:0] rtag   [8];
    logic [31:0] ref_words [logic [29:0]];

    initial begin
        int st;
        logic [31:0] rd;
        int n;
        int exp_miss;

        vecs[0] = '{1'b1, 1'b0, 30'h10, 32'h0,          4, 1'b1, 32'hC000_0040};
        vecs[1] = '{1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF,  0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 30'h11, 32'h0,          0, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 30'h30, 32'h0,          7, 1'b1, 32'hC000_00C0};
        vecs[4] = '{1'b1, 1'b0, 30'h11, 32'h0,          4, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b1, 30'h12, 32'h1234_5678,  0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 30'h12, 32'h0,          0, 1'b1, 32'h1234_5678};
        vecs[7] = '{1'b1, 1'b0, 30'h10, 32'h0,          0, 1'b1, 32'hC000_0040};
        vecs[8] = '{1'b1, 1'b0, 30'h00, 32'h0,          4, 1'b1, 32'hC000_0000};

        // reset values
        #12;
        chk("rst_stall", 128'(proc_stall), 128'(0));
        chk("rst_rdata", 128'(proc_rdata), 128'(0));
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        lat = 3;
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, st, rd);
            chk($sformatf("vec%0d_stall", i), 128'(st), 128'(vecs[i].exp_stall));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rd));
        end

        // eviction order: write-back of the dirty line before the fill
        chk("log_size", 128'(ev_log.size()), 128'(5));
        chk("wb_is_write", 128'(ev_log[1].is_wr), 128'(1));
        chk("wb_addr", 128'(ev_log[1].addr), 128'(28'h4));
        chk("wb_data_w1", 128'(ev_log[1].data[63:32]), 128'(32'hDEAD_BEEF));
        chk("fill_after_wb", 128'(ev_log[2].is_wr), 128'(0));
        chk("fill_addr", 128'(ev_log[2].addr), 128'(28'hC));

        // read+write was a write: line is dirty and holds the new word
        n = ev_log.size();
        access(1'b1, 1'b0, 30'h30, 32'h0, st, rd);
        chk("rw_evict_stall", 128'(st), 128'(7));
        chk("rw_evict_is_wb", 128'(ev_log[n].is_wr), 128'(1));
        chk("rw_evict_w2", 128'(ev_log[n].data[95:64]), 128'(32'h1234_5678));
        chk("rw_evict_w1", 128'(ev_log[n].data[63:32]), 128'(32'hDEAD_BEEF));

        // idle, no request, stray mem_ready
        #1;
        stray_ready = 1'b1;
        @(negedge clk);
        chk("idle_stall", 128'(proc_stall), 128'(0));
        @(posedge clk);
        #2;
        stray_ready = 1'b0;
        @(negedge clk);
        chk("stray_mem_read", 128'(mem_read), 128'(0));
        chk("stray_mem_write", 128'(mem_write), 128'(0));
        @(posedge clk);
        #1;

        // reset in the middle of ALLOCATE
        lat = 20;
        proc_read = 1'b1;
        proc_addr = 30'h200;
        @(posedge clk);
        #1;
        chk("alloc_mem_read", 128'(mem_read), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_read", 128'(mem_read), 128'(0));
        chk("rst_async_mem_write", 128'(mem_write), 128'(0));
        @(posedge clk);
        #1;
        proc_read = 1'b0;
        rst_n = 1'b1;
        lat = 2;
        access(1'b1, 1'b0, 30'h200, 32'h0, st, rd);
        chk("post_rst_miss_stall", 128'(st), 128'(3));
        chk("post_rst_miss_rdata", 128'(rd), 128'(32'hC000_0800));
        access(1'b1, 1'b0, 30'h10, 32'h0, st, rd);
        chk("post_rst_old_stall", 128'(st), 128'(3));
        chk("post_rst_old_rdata", 128'(rd), 128'(32'hC000_0040));

        // randomized traffic against a flat-memory + residency model
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_model.delete();
        ev_log.delete();
        ref_words.delete();
        for (int i = 0; i < 8; i++) begin
            rvalid[i] = 1'b0; rdirty[i] = 1'b0; rtag[i] = '0;
        end
        exp_miss = 0;
        for (int t = 0; t < 300; t++) begin
            int op, ix, tg, w, es;
            bit r, wr, h;
            logic [29:0] a;
            logic [31:0] wd, er;
            op = $urandom_range(0, 2);
            tg = $urandom_range(0, 3);
            ix = $urandom_range(0, 7);
            w  = $urandom_range(0, 3);
            lat = $urandom_range(1, 4);
            wd = $urandom;
            r  = (op != 1);
            wr = (op != 0);
            a  = 30'(tg * 32 + ix * 4 + w);
            h  = rvalid[ix] && (rtag[ix] == 25'(tg));
            if (h) es = 0;
            else es = (rvalid[ix] && rdirty[ix]) ? 2 * lat + 1 : lat + 1;
            if (!h) begin
                exp_miss++;
                rvalid[ix] = 1'b1; rtag[ix] = 25'(tg); rdirty[ix] = 1'b0;
            end
            er = ref_words.exists(a) ? ref_words[a] : init_word(a);
            if (wr) begin
                ref_words[a] = wd;
                rdirty[ix] = 1'b1;
            end
            access(r, wr, a, wd, st, rd);
            chk($sformatf("rand%0d_stall", t), 128'(st), 128'(es));
            if (r && !wr) chk($sformatf("rand%0d_rdata", t), 128'(rd), 128'(er));
        end
`ifdef DCACHE_STATS_EN
        chk("hit_count", 128'(hit_count), 128'(300));
        chk("miss_count", 128'(miss_count), 128'(exp_miss));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
